shared_reg_arbiter: RTL

Round-robin arbiter and write sequencer for a single shared WIDTH-bit data register built from D flip-flops. Up to four requesters compete for the register; the block grants one at a time, loads that requester's data into the register, holds the grant until the requester releases, then rotates priority. It sits between the lab's input-capture logic and the shared register that drives the display/output datapath.

---
 rtl/shared_reg_arbiter_if.sv | 28 ++
 rtl/shared_reg_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter.
interface shared_reg_arbiter_if #(
    parameter int WIDTH = 8
);
    // Handshake: a requester raises req[i] and keeps it high until it sees grant[i];
    // the register is loaded from its wdata slice one cycle after the grant appears
    // (wr_done marks the cycle after the load), and the requester ends its
    // ownership by dropping req[i]. A request that drops before it is granted is lost.
    logic [3:0]         req;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         grant;
    logic               busy;
    logic [WIDTH-1:0]   q;
    logic               wr_done;
    logic [1:0]         owner;
    logic [7:0]         wcount;
    logic [1:0]         state;   // FSM state for debug/checkers: 0 IDLE, 1 LOAD, 2 HOLD

    modport master (
        output req, wdata,
        input  grant, busy, q, wr_done, owner, wcount, state
    );

    modport slave (
        input  req, wdata,
        output grant, busy, q, wr_done, owner, wcount, state
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
module shared_reg_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    shared_reg_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       owner_q;
    logic [3:0]       grant_q;
    logic [WIDTH-1:0] q_q;
    logic             wr_done_q;
    logic [7:0]       wcount_q;

    logic [7:0]       req_dbl;
    logic [7:0]       req_rot_full;
    logic [3:0]       req_rot;
    logic [1:0]       offset_d;
    logic [1:0]       winner_d;

    // Rotate requests so bit 0 is the pointer's requester, then pick the first set bit.
    always_comb begin
        req_dbl      = {bus.req, bus.req};
        req_rot_full = req_dbl >> ptr_q;
        req_rot      = req_rot_full[3:0];
        offset_d     = 2'd3;
        if (req_rot[0]) begin
            offset_d = 2'd0;
        end else if (req_rot[1]) begin
            offset_d = 2'd1;
        end else if (req_rot[2]) begin
            offset_d = 2'd2;
        end
        winner_d = ptr_q + offset_d;
    end

    // Arbitration FSM: all outputs are registered so grant only moves through 0000.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            grant_q   <= 4'b0000;
            q_q       <= '0;
            wr_done_q <= 1'b0;
            wcount_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_done_q <= 1'b0;
                    if (bus.req != 4'b0000) begin
                        grant_q <= 4'b0001 << winner_d;
                        owner_q <= winner_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // The write commits even if the owner already dropped its request.
                    q_q       <= bus.wdata[owner_q*WIDTH +: WIDTH];
                    wcount_q  <= wcount_q + 8'd1;
                    wr_done_q <= 1'b1;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    wr_done_q <= 1'b0;
                    if (!bus.req[owner_q]) begin
                        grant_q <= 4'b0000;
                        ptr_q   <= owner_q + 2'd1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q   <= 4'b0000;
                    wr_done_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.q       = q_q;
    assign bus.wr_done = wr_done_q;
    assign bus.owner   = owner_q;
    assign bus.wcount  = wcount_q;
    assign bus.state   = state_q;
endmodule
